keypad_matrix_scan: RTL

- Upstream stage of the watch/time-set logic.
- Scans a 4-row x 3-column membrane keypad, synchronizes and debounces it, and presents digits as a 10-bit one-hot level vector, bit n = digit n, held while the key stays pressed.
- '*' and '#' are reported on a separate 2-bit function output for mode/alarm control.
- Runs on the 1 kHz system clock.

---
 rtl/keypad_matrix_scan.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scan
// Description : 4x3 membrane keypad scanner with row synchronizer, multi-key
//               rejection, scan-level debounce and one-hot digit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scan #(
    parameter int COL_DWELL      = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [9:0] keypad,
    output logic [1:0] key_func,
    output logic       key_valid,
    output logic       key_press
);

    localparam int              c_DW         = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(COL_DWELL - 1);
    localparam logic [3:0]      c_DEB        = 4'(DEBOUNCE_SCANS);

    localparam logic [3:0] c_CODE_STAR = 4'd10;
    localparam logic [3:0] c_CODE_HASH = 4'd11;
    localparam logic [3:0] c_CODE_NONE = 4'd15;

    // State value doubles as the index of the column being driven
    localparam logic [1:0] c_ST_COL0 = 2'd0;
    localparam logic [1:0] c_ST_COL1 = 2'd1;
    localparam logic [1:0] c_ST_COL2 = 2'd2;

    logic [3:0]      r_row_meta;
    logic [3:0]      r_row_sync;
    logic [c_DW-1:0] r_dwell;
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            w_sample;
    logic            w_scan_done;

    logic [3:0]      w_row_act;
    logic [1:0]      w_col_hits;
    logic [1:0]      w_col_row;
    logic [1:0]      r_hits;
    logic [3:0]      r_hit_code;
    logic [1:0]      w_hits_new;
    logic [3:0]      w_code_new;
    logic [3:0]      w_result;

    logic [3:0]      r_cand;
    logic [3:0]      r_stable_cnt;
    logic [3:0]      r_committed;
    logic [3:0]      w_cand_next;
    logic [3:0]      w_cnt_next;
    logic            w_commit;

    function automatic logic [3:0] f_key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = c_CODE_STAR;
                2'd1:    code = 4'd0;
                default: code = c_CODE_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Rows are sampled on the last dwell cycle, once the sync chain has settled
    assign w_sample    = (r_dwell == c_DWELL_LAST);
    assign w_scan_done = w_sample && (r_state == c_ST_COL2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_COL0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_sample) begin
            case (r_state)
                c_ST_COL0: w_state_next = c_ST_COL1;
                c_ST_COL1: w_state_next = c_ST_COL2;
                default:   w_state_next = c_ST_COL0;
            endcase
        end
    end

    always_comb begin
        col_n = 3'b110;
        case (r_state)
            c_ST_COL1: col_n = 3'b101;
            c_ST_COL2: col_n = 3'b011;
            default:   col_n = 3'b110;
        endcase
    end

    // Per-column hit count saturates at 2, meaning "two or more"
    always_comb begin
        w_row_act  = ~r_row_sync;
        w_col_hits = 2'd0;
        w_col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (w_row_act[r]) begin
                w_col_row  = 2'(r);
                w_col_hits = (w_col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    always_comb begin
        w_hits_new = r_hits;
        w_code_new = r_hit_code;
        if (w_col_hits != 2'd0) begin
            if (r_hits == 2'd0) begin
                w_hits_new = w_col_hits;
                w_code_new = f_key_code(w_col_row, r_state);
            end else begin
                w_hits_new = 2'd2;
            end
        end
    end

    assign w_result = (w_hits_new == 2'd1) ? w_code_new : c_CODE_NONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hits     <= 2'd0;
            r_hit_code <= c_CODE_NONE;
        end else if (w_scan_done) begin
            r_hits     <= 2'd0;
            r_hit_code <= c_CODE_NONE;
        end else if (w_sample) begin
            r_hits     <= w_hits_new;
            r_hit_code <= w_code_new;
        end
    end

    always_comb begin
        w_cand_next = r_cand;
        w_cnt_next  = r_stable_cnt;
        if (w_scan_done) begin
            if (w_result == r_cand) begin
                w_cnt_next = (r_stable_cnt >= c_DEB) ? c_DEB : r_stable_cnt + 4'd1;
            end else begin
                w_cand_next = w_result;
                w_cnt_next  = 4'd1;
            end
        end
    end

    assign w_commit = w_scan_done && (w_cnt_next == c_DEB) && (w_cand_next != r_committed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand       <= c_CODE_NONE;
            r_stable_cnt <= 4'd0;
        end else begin
            r_cand       <= w_cand_next;
            r_stable_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_committed <= c_CODE_NONE;
            keypad      <= 10'd0;
            key_func    <= 2'b00;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (w_commit) begin
                r_committed <= w_cand_next;
                key_valid   <= (w_cand_next != c_CODE_NONE);
                key_press   <= (w_cand_next != c_CODE_NONE);
                keypad      <= (w_cand_next < 4'd10) ? (10'd1 << w_cand_next) : 10'd0;
                key_func    <= {(w_cand_next == c_CODE_HASH), (w_cand_next == c_CODE_STAR)};
            end
        end
    end

endmodule
`default_nettype wire
